// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit
// Description : ID-stage hazard detector and destination-tag tracker for a
//               5-stage ARM pipeline (IF/ID/EXE/MEM/WB). Keeps a shadow copy
//               of the destination tags of the instructions in EXE, MEM and
//               WB, exports the MEM/WB tags to the forwarding selects, raises
//               hazard_stall when an ID source cannot be forwarded, and counts
//               stall cycles with a saturating counter.
// Ports       : clk, rst (sync, active-low)
//               en_forwarding, freeze, flush            - pipeline control
//               id_valid, id_src1, id_src2, id_two_src,
//               id_dest, id_wb_en, id_mem_read          - ID instruction
//               hazard_stall                            - stall request
//               mem_dest/mem_wb_en, wb_dest/wb_wb_en    - forwarding tags
//               state (00 RUN, 01 STALL, 10 FROZEN), stall_cnt
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detection_unit #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_forwarding,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    output logic              hazard_stall,
    output logic [REG_AW-1:0] mem_dest,
    output logic              mem_wb_en,
    output logic [REG_AW-1:0] wb_dest,
    output logic              wb_wb_en,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL  = 2'b01,
        ST_FROZEN = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    // Shadow pipeline registers
    logic [REG_AW-1:0] r_exe_dest;
    logic              r_exe_wb_en;
    logic              r_exe_mem_read;
    logic [REG_AW-1:0] r_mem_dest;
    logic              r_mem_wb_en;
    logic [REG_AW-1:0] r_wb_dest;
    logic              r_wb_wb_en;
    logic [CNT_W-1:0]  r_stall_cnt;
    state_t            r_state;
    state_t            w_state_next;

    logic w_src1_exe, w_src2_exe, w_src1_mem, w_src2_mem;
    logic w_dep_exe, w_dep_mem;
    logic w_hazard_raw;
    logic w_hazard_stall;
    logic w_exe_bubble;

    // Source matches against in-flight destinations. WB is deliberately
    // excluded: the register file writes on the falling edge, so ID reads
    // the fresh value in the same cycle.
    assign w_src1_exe = r_exe_wb_en && (r_exe_dest == id_src1);
    assign w_src2_exe = id_two_src && r_exe_wb_en && (r_exe_dest == id_src2);
    assign w_src1_mem = r_mem_wb_en && (r_mem_dest == id_src1);
    assign w_src2_mem = id_two_src && r_mem_wb_en && (r_mem_dest == id_src2);
    assign w_dep_exe  = w_src1_exe || w_src2_exe;
    assign w_dep_mem  = w_src1_mem || w_src2_mem;

    // With forwarding only a load in EXE is unservable (data not yet read);
    // without it, any producer still in EXE or MEM blocks the read.
    assign w_hazard_raw = en_forwarding ? (w_dep_exe && r_exe_mem_read)
                                        : (w_dep_exe || w_dep_mem);

    // Stall is suppressed in reset, while frozen (tags are held, so the
    // hazard reappears once freeze drops) and when the ID slot is dead.
    assign w_hazard_stall = rst && !freeze && !flush && id_valid && w_hazard_raw;

    assign w_exe_bubble = flush || w_hazard_stall || !id_valid;

    // Shadow pipeline advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exe_dest     <= '0;
            r_exe_wb_en    <= 1'b0;
            r_exe_mem_read <= 1'b0;
            r_mem_dest     <= '0;
            r_mem_wb_en    <= 1'b0;
            r_wb_dest      <= '0;
            r_wb_wb_en     <= 1'b0;
        end else if (!freeze) begin
            if (w_exe_bubble) begin
                r_exe_dest     <= '0;
                r_exe_wb_en    <= 1'b0;
                r_exe_mem_read <= 1'b0;
            end else begin
                r_exe_dest     <= id_dest;
                r_exe_wb_en    <= id_wb_en;
                r_exe_mem_read <= id_mem_read;
            end
            r_mem_dest  <= r_exe_dest;
            r_mem_wb_en <= r_exe_wb_en;
            r_wb_dest   <= r_mem_dest;
            r_wb_wb_en  <= r_mem_wb_en;
        end
    end

    // Saturating stall-cycle counter (stall is already masked by freeze)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard_stall && (r_stall_cnt != C_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: the same priority applies from every state, so
    // FROZEN exits to STALL or RUN on the first cycle freeze is low.
    always_comb begin
        w_state_next = ST_RUN;
        if (freeze) begin
            w_state_next = ST_FROZEN;
        end else if (w_hazard_stall) begin
            w_state_next = ST_STALL;
        end
    end

    assign hazard_stall = w_hazard_stall;
    assign mem_dest     = r_mem_dest;
    assign mem_wb_en    = r_mem_wb_en;
    assign wb_dest      = r_wb_dest;
    assign wb_wb_en     = r_wb_wb_en;
    assign state        = r_state;
    assign stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire
